// File: rtl/dma_desc_sched.sv
// Descriptor-queue DMA scheduler: runs queued descriptors back-to-back through the read/write streamers.
// Optional stall watchdog is enabled by defining DMA_WDOG_EN.
//
// state  | meaning
// IDLE   | waiting for a queued descriptor
// LOAD   | pop queue head into cur_* (zero-length retires here)
// RUN    | streamers active until both done and AXI drained
// DRAIN  | halted (abort/error), waiting for AXI to drain before flush
// DONE   | one-cycle clear_dma_o, then back to IDLE
module dma_desc_sched #(
    parameter int ADDR_W      = 32,
    parameter int BYTES_W     = 32,
    parameter int DESC_DEPTH  = 4,
    parameter int CNT_W       = 16,
    parameter int HALT_ON_ERR = 1,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          desc_valid_i,
    output logic                          desc_ready_o,
    input  logic [ADDR_W-1:0]             desc_src_addr_i,
    input  logic [ADDR_W-1:0]             desc_dst_addr_i,
    input  logic [BYTES_W-1:0]            desc_num_bytes_i,
    input  logic                          abort_i,
    input  logic                          error_clr_i,
    input  logic                          axi_pend_txn_i,
    input  logic                          axi_err_valid_i,
    input  logic                          axi_err_src_i,
    input  logic [ADDR_W-1:0]             axi_err_addr_i,
    output logic                          stream_rd_valid_o,
    input  logic                          stream_rd_done_i,
    input  logic                          stream_rd_err_valid_i,
    input  logic [ADDR_W-1:0]             stream_rd_err_addr_i,
    output logic                          stream_wr_valid_o,
    input  logic                          stream_wr_done_i,
    input  logic                          stream_wr_err_valid_i,
    input  logic [ADDR_W-1:0]             stream_wr_err_addr_i,
    output logic [ADDR_W-1:0]             cur_src_addr_o,
    output logic [ADDR_W-1:0]             cur_dst_addr_o,
    output logic [BYTES_W-1:0]            cur_num_bytes_o,
    output logic                          dma_active_o,
    output logic                          clear_dma_o,
    output logic                          desc_done_o,
    output logic [CNT_W-1:0]              done_cnt_o,
    output logic [$clog2(DESC_DEPTH):0]   queue_level_o,
    output logic                          error_valid_o,
    output logic [1:0]                    error_src_o,
    output logic [ADDR_W-1:0]             error_addr_o,
    output logic [CNT_W-1:0]              error_desc_idx_o
);

    localparam int PTR_W = $clog2(DESC_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic HALT = (HALT_ON_ERR != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;

    logic [ADDR_W-1:0]  src_q [DESC_DEPTH];
    logic [ADDR_W-1:0]  dst_q [DESC_DEPTH];
    logic [BYTES_W-1:0] len_q [DESC_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;

    logic               rd_done_ff;
    logic               wr_done_ff;
    logic               run_done;
    logic               err_lock;
    logic [CNT_W-1:0]   done_cnt;
    logic               err_valid;
    logic [1:0]         err_src;
    logic [ADDR_W-1:0]  err_addr;
    logic [CNT_W-1:0]   err_idx;

    logic               full;
    logic               push;
    logic               pop;
    logic               flush;
    logic [ADDR_W-1:0]  head_src;
    logic [ADDR_W-1:0]  head_dst;
    logic [BYTES_W-1:0] head_len;
    logic               load_zero;
    logic               run_retire;
    logic               retire;
    logic               more_after_load;
    logic               more_after_run;
    logic               err_state;
    logic               any_err;
    logic               capture;
    logic               halt;
    logic [1:0]         cap_src;
    logic [ADDR_W-1:0]  cap_addr;
    logic               wdog_err;

    assign full     = (level == LVL_W'(DESC_DEPTH));
    assign push     = desc_valid_i && desc_ready_o;
    assign pop      = (state == S_LOAD);
    assign flush    = ((state == S_IDLE) && abort_i) || ((state == S_DRAIN) && !axi_pend_txn_i);
    assign head_src = src_q[rd_ptr];
    assign head_dst = dst_q[rd_ptr];
    assign head_len = len_q[rd_ptr];

    // A zero-length descriptor is complete the moment it is loaded, so it retires in LOAD unconditionally.
    assign load_zero  = (state == S_LOAD) && (head_len == '0);
    assign run_retire = (state == S_RUN) && rd_done_ff && wr_done_ff && !axi_pend_txn_i
                        && !abort_i && !halt;
    assign retire     = load_zero || run_retire;

    // Count a same-cycle push so DONE is never entered with a descriptor waiting.
    assign more_after_load = (level > LVL_W'(1)) || push;
    assign more_after_run  = (level != '0) || push;

    assign err_state = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
    assign any_err   = axi_err_valid_i || stream_rd_err_valid_i || stream_wr_err_valid_i || wdog_err;
    assign capture   = err_state && any_err && (!err_lock || error_clr_i);
    assign halt      = capture && HALT;

    always_comb begin
        cap_src  = 2'b00;
        cap_addr = '0;
        if (axi_err_valid_i) begin
            cap_src  = {1'b1, axi_err_src_i};
            cap_addr = axi_err_addr_i;
        end else if (stream_rd_err_valid_i) begin
            cap_src  = 2'b00;
            cap_addr = stream_rd_err_addr_i;
        end else if (stream_wr_err_valid_i) begin
            cap_src  = 2'b01;
            cap_addr = stream_wr_err_addr_i;
        end else if (wdog_err) begin
            cap_src  = 2'b11;
            cap_addr = cur_src_addr_o;
        end
    end

`ifdef DMA_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if ((state == S_LOAD) || stream_rd_done_i || stream_wr_done_i) begin
            wdog_cnt <= '0;
        end else if ((state == S_RUN) && (wdog_cnt != WD_W'(WDOG_CYCLES))) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_err = (state == S_RUN) && (wdog_cnt == WD_W'(WDOG_CYCLES));
`else
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DESC_DEPTH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                src_q[wr_ptr] <= desc_src_addr_i;
                dst_q[wr_ptr] <= desc_dst_addr_i;
                len_q[wr_ptr] <= desc_num_bytes_i;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            cur_src_addr_o  <= '0;
            cur_dst_addr_o  <= '0;
            cur_num_bytes_o <= '0;
            rd_done_ff      <= 1'b0;
            wr_done_ff      <= 1'b0;
            run_done        <= 1'b0;
            done_cnt        <= '0;
            err_lock        <= 1'b0;
            err_valid       <= 1'b0;
            err_src         <= 2'b00;
            err_addr        <= '0;
            err_idx         <= '0;
        end else begin
            run_done <= run_retire;
            if (retire && (done_cnt != {CNT_W{1'b1}})) begin
                done_cnt <= done_cnt + 1'b1;
            end

            if (capture) begin
                err_lock  <= 1'b1;
                err_valid <= 1'b1;
                err_src   <= cap_src;
                err_addr  <= cap_addr;
                err_idx   <= done_cnt;
            end else if (error_clr_i) begin
                err_lock  <= 1'b0;
                err_valid <= 1'b0;
                err_src   <= 2'b00;
                err_addr  <= '0;
                err_idx   <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (!abort_i && (level != '0)) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cur_src_addr_o  <= head_src;
                    cur_dst_addr_o  <= head_dst;
                    cur_num_bytes_o <= head_len;
                    rd_done_ff      <= 1'b0;
                    wr_done_ff      <= 1'b0;
                    if (abort_i || halt) begin
                        state <= S_DRAIN;
                    end else if (load_zero) begin
                        state <= more_after_load ? S_LOAD : S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stream_rd_valid_o && stream_rd_done_i) begin
                        rd_done_ff <= 1'b1;
                    end
                    if (stream_wr_valid_o && stream_wr_done_i) begin
                        wr_done_ff <= 1'b1;
                    end
                    if (abort_i || halt) begin
                        state <= S_DRAIN;
                    end else if (run_retire) begin
                        state <= more_after_run ? S_LOAD : S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (!axi_pend_txn_i) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign desc_ready_o      = !full && (state != S_DRAIN);
    assign stream_rd_valid_o = (state == S_RUN) && !rd_done_ff;
    assign stream_wr_valid_o = (state == S_RUN) && !wr_done_ff;
    assign dma_active_o      = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
    assign clear_dma_o       = (state == S_DONE);
    assign desc_done_o       = run_done || load_zero;
    assign done_cnt_o        = done_cnt;
    assign queue_level_o     = level;
    assign error_valid_o     = err_valid;
    assign error_src_o       = err_src;
    assign error_addr_o      = err_addr;
    assign error_desc_idx_o  = err_idx;

endmodule
